// File: rtl/collide_pkg.sv
// Shared types and constants for the tile collision responder.
package collide_pkg;

    localparam int unsigned MAP_DIM = 32;

    typedef logic [4:0]  tile_t;
    typedef logic [31:0] map_row_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } coll_state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for a slow asynchronous clock plus a one-cycle falling-edge pulse.
module edge_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // r_prev clears to 0 so a low or high input after reset never looks like a fall
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/tile_collider.sv
// Once-per-frame wall lookup in a host-loaded 32x32 tile map for the motion block.
module tile_collider
    import collide_pkg::*;
#(
    parameter int unsigned COLS = 20,
    parameter int unsigned ROWS = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [4:0]  X_coll,
    input  logic [4:0]  Y_coll,
    input  logic        map_we,
    input  logic [4:0]  map_row,
    input  logic [31:0] map_data,
    output logic        coll_next,
    output logic        coll_valid
);

    map_row_t    r_map [MAP_DIM];
    coll_state_t r_state;
    tile_t       r_xq;
    tile_t       r_yq;
    map_row_t    r_row_q;
    logic        r_coll_next;
    logic        r_coll_valid;

    logic w_fall;
    logic w_oob;

    edge_sync u_edge_sync (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_async (frame_clk),
        .o_fall  (w_fall)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < MAP_DIM; i++) begin
                r_map[i] <= '0;
            end
        end else if (map_we) begin
            r_map[map_row] <= map_data;
        end
    end

    assign w_oob = (32'(r_xq) >= COLS) || (32'(r_yq) >= ROWS);

    // Falls seen outside IDLE are dropped; the query in flight completes untouched.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_xq         <= '0;
            r_yq         <= '0;
            r_row_q      <= '0;
            r_coll_next  <= 1'b0;
            r_coll_valid <= 1'b0;
        end else begin
            r_coll_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_xq    <= X_coll;
                        r_yq    <= Y_coll;
                        r_state <= READ;
                    end
                end
                READ: begin
                    r_row_q <= r_map[r_yq];
                    r_state <= RESP;
                end
                RESP: begin
                    r_coll_next  <= w_oob | r_row_q[r_xq];
                    r_coll_valid <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign coll_next  = r_coll_next;
    assign coll_valid = r_coll_valid;

endmodule
